// File: rtl/nou_flit_pkg.sv
// Shared types and elaboration-time helpers for the NOU flit serializer.
package nou_flit_pkg;

  typedef enum logic {StIdle, StSend} state_e;

  // Number of flits needed to carry one entry (ceiling division).
  function automatic int unsigned flits_per_request(input int unsigned entry_w,
                                                    input int unsigned flit_w);
    return (entry_w + flit_w - 1) / flit_w;
  endfunction

  // Beat counter width; never narrower than one bit.
  function automatic int unsigned beat_width(input int unsigned flits);
    return (flits <= 1) ? 1 : $clog2(flits);
  endfunction

  // Parameter legality: flit count 1..256, credits fit in the counter.
  function automatic bit params_legal(input int unsigned entry_w, input int unsigned flit_w,
                                      input int unsigned credit_w,
                                      input int unsigned max_credits);
    int unsigned flits;
    if (entry_w == 0 || flit_w == 0 || credit_w == 0 || credit_w > 31) return 1'b0;
    flits = flits_per_request(entry_w, flit_w);
    if (flits < 1 || flits > 256) return 1'b0;
    if (max_credits < 1 || max_credits > ((32'd1 << credit_w) - 1)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/nou_credit_counter.sv
// Link credit counter: one credit spent per flit, one returned per credit_return pulse.
// A return that would exceed the maximum is dropped and latches a sticky overflow flag.
module nou_credit_counter #(
  parameter int unsigned CREDIT_WIDTH_IN_BITS = 3,
  parameter int unsigned MAX_CREDITS          = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            spend_i,
  input  logic                            return_i,
  output logic [CREDIT_WIDTH_IN_BITS-1:0] count_o,
  output logic                            has_credit_o,
  output logic                            overflow_o
);

  localparam logic [CREDIT_WIDTH_IN_BITS-1:0] MaxCount = CREDIT_WIDTH_IN_BITS'(MAX_CREDITS);
  localparam logic [CREDIT_WIDTH_IN_BITS-1:0] One      = CREDIT_WIDTH_IN_BITS'(1);

  logic [CREDIT_WIDTH_IN_BITS-1:0] count_q, count_d;
  logic                            overflow_q, overflow_d;

  // Next credit count; simultaneous spend and return cancel out.
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (spend_i && !return_i) begin
      count_d = count_q - One;
    end else if (return_i && !spend_i) begin
      if (count_q == MaxCount) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + One;
      end
    end
  end

  // Credit and sticky error state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q    <= MaxCount;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count_o      = count_q;
  assign has_credit_o = (count_q != '0);
  assign overflow_o   = overflow_q;

endmodule

// File: rtl/nou_flit_serializer.sv
// Serializes one wide NOU request FIFO entry into LSB-first flits on a credit-controlled link.
// Optional macro NOU_FLIT_SERIALIZER_BACK_TO_BACK_EN: accept the next entry on the tail flit so
// packets follow each other with no idle bubble.
module nou_flit_serializer
  import nou_flit_pkg::*;
#(
  parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int unsigned FLIT_WIDTH_IN_BITS         = 16,
  parameter int unsigned CREDIT_WIDTH_IN_BITS       = 3,
  parameter int unsigned MAX_CREDITS                = 4
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
  input  logic                                  request_valid_in,
  output logic                                  issue_ack_out,
  output logic [FLIT_WIDTH_IN_BITS-1:0]         flit_out,
  output logic                                  flit_valid_out,
  output logic                                  flit_head_out,
  output logic                                  flit_tail_out,
  input  logic                                  credit_return_in,
  output logic [CREDIT_WIDTH_IN_BITS-1:0]       credit_count_out,
  output logic                                  busy_out,
  output logic                                  credit_overflow_out
);

  localparam int unsigned FlitsPerRequest =
      flits_per_request(SINGLE_ENTRY_WIDTH_IN_BITS, FLIT_WIDTH_IN_BITS);
  localparam int unsigned BeatWidth  = beat_width(FlitsPerRequest);
  localparam int unsigned ShiftWidth = FlitsPerRequest * FLIT_WIDTH_IN_BITS;
  localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(FlitsPerRequest - 1);
  localparam logic [BeatWidth-1:0] OneBeat  = BeatWidth'(1);

  if (!params_legal(SINGLE_ENTRY_WIDTH_IN_BITS, FLIT_WIDTH_IN_BITS, CREDIT_WIDTH_IN_BITS,
                    MAX_CREDITS)) begin : g_bad_params
    $error("nou_flit_serializer: illegal parameter combination");
  end

  state_e                  state_q;
  logic [ShiftWidth-1:0]   shift_q;
  logic [BeatWidth-1:0]    beat_q;
  logic                    has_credit;
  logic                    flit_valid;
  logic                    beat_is_head;
  logic                    beat_is_tail;
  logic                    issue_ack;

  // Flit qualifiers come from registers only, never from credit_return_in.
  assign flit_valid   = (state_q == StSend) && has_credit;
  assign beat_is_head = (beat_q == '0);
  assign beat_is_tail = (beat_q == LastBeat);

  // FIFO issue acknowledge; capture never waits for credits.
  always_comb begin
    issue_ack = 1'b0;
    case (state_q)
      StIdle: issue_ack = request_valid_in;
      StSend: begin
`ifdef NOU_FLIT_SERIALIZER_BACK_TO_BACK_EN
        issue_ack = flit_valid && beat_is_tail && request_valid_in;
`else
        issue_ack = 1'b0;
`endif
      end
      default: issue_ack = 1'b0;
    endcase
  end

  // Packet FSM, shift register and beat counter.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= StIdle;
      shift_q <= '0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (issue_ack) begin
            shift_q <= ShiftWidth'(request_in);
            beat_q  <= '0;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (flit_valid) begin
            shift_q <= shift_q >> FLIT_WIDTH_IN_BITS;
            beat_q  <= beat_q + OneBeat;
            if (beat_is_tail) begin
`ifdef NOU_FLIT_SERIALIZER_BACK_TO_BACK_EN
              if (issue_ack) begin
                shift_q <= ShiftWidth'(request_in);
                beat_q  <= '0;
              end else begin
                state_q <= StIdle;
              end
`else
              state_q <= StIdle;
`endif
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  nou_credit_counter #(
    .CREDIT_WIDTH_IN_BITS(CREDIT_WIDTH_IN_BITS),
    .MAX_CREDITS         (MAX_CREDITS)
  ) u_credit_counter (
    .clk_i       (clk_in),
    .rst_i       (reset_in),
    .spend_i     (flit_valid),
    .return_i    (credit_return_in),
    .count_o     (credit_count_out),
    .has_credit_o(has_credit),
    .overflow_o  (credit_overflow_out)
  );

  assign issue_ack_out  = issue_ack;
  assign flit_out       = shift_q[FLIT_WIDTH_IN_BITS-1:0];
  assign flit_valid_out = flit_valid;
  assign flit_head_out  = flit_valid && beat_is_head;
  assign flit_tail_out  = flit_valid && beat_is_tail;
  assign busy_out       = (state_q == StSend);

endmodule
